nec_tx_ext: RTL and testbench

NEC_TX_EXT -- requirements
Module: nec_tx_ext

---
 rtl/nec_pkg.sv | 39 +++
 rtl/nec_carrier_gen.sv | 49 ++++
 rtl/nec_tx_ext.sv | 151 +++++++++++++++
 tb/tb_nec_tx_ext.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_pkg.sv
// NEC IR transmitter shared types: FSM states, microsecond timings, helpers.
package nec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP,
        REP_MARK,
        REP_SPACE,
        REP_STOP
    } state_e;

    localparam int unsigned LEAD_MARK_US    = 9000;
    localparam int unsigned LEAD_SPACE_US   = 4500;
    localparam int unsigned BIT_MARK_US     = 562;
    localparam int unsigned BIT0_SPACE_US   = 562;
    localparam int unsigned BIT1_SPACE_US   = 1687;
    localparam int unsigned REP_SPACE_US    = 2250;
    localparam int unsigned STOP_MARK_US    = 562;
    localparam int unsigned FRAME_PERIOD_US = 108000;

    // Integer clock cycles for a duration in microseconds (64-bit intermediate).
    function automatic logic [31:0] us_to_cycles(input int unsigned us, input int unsigned clk_freq);
        logic [63:0] prod;
        prod = 64'(us) * 64'(clk_freq);
        return 32'(prod / 64'd1_000_000);
    endfunction

    // States during which the envelope is high.
    function automatic logic is_mark(input state_e s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) ||
               (s == REP_MARK)  || (s == REP_STOP);
    endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// Carrier phase generator: restarts high on request, toggles every HALF cycles,
// and presents a registered carrier gated by the mark envelope.
module nec_carrier_gen
    import nec_pkg::*;
#(
    parameter int unsigned HALF = 1644
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic gate_i,
    output logic phase_o
);

    localparam logic [31:0] HALF_M1 = 32'(HALF - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        ph_q, ph_d;
    logic        out_q;

    // Next carrier phase: forced high on restart, otherwise toggle each half-period.
    always_comb begin
        cnt_d = 32'(cnt_q + 32'd1);
        ph_d  = ph_q;
        if (restart_i) begin
            cnt_d = '0;
            ph_d  = 1'b1;
        end else if (cnt_q == HALF_M1) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
        end
    end

    // Phase counter and gated output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            out_q <= gate_i & ph_d;
        end
    end

    assign phase_o = out_q;

endmodule

// File: rtl/nec_tx_ext.sv
// NEC / extended-NEC IR frame transmitter with repeat codes and optional carrier.
module nec_tx_ext
    import nec_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 125_000_000,
    parameter int unsigned CARRIER_FREQ = 38_000,
    parameter bit          MODULATE     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  cmd,
    input  logic        ext_addr,
    input  logic        send,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic        envelope,
    output logic        ir_out
);

    localparam int unsigned HALF = CLK_FREQ / (2 * CARRIER_FREQ);

    localparam logic [31:0] T_LEAD_MARK  = us_to_cycles(LEAD_MARK_US, CLK_FREQ);
    localparam logic [31:0] T_LEAD_SPACE = us_to_cycles(LEAD_SPACE_US, CLK_FREQ);
    localparam logic [31:0] T_BIT_MARK   = us_to_cycles(BIT_MARK_US, CLK_FREQ);
    localparam logic [31:0] T_BIT0_SPACE = us_to_cycles(BIT0_SPACE_US, CLK_FREQ);
    localparam logic [31:0] T_BIT1_SPACE = us_to_cycles(BIT1_SPACE_US, CLK_FREQ);
    localparam logic [31:0] T_REP_SPACE  = us_to_cycles(REP_SPACE_US, CLK_FREQ);
    localparam logic [31:0] T_STOP_MARK  = us_to_cycles(STOP_MARK_US, CLK_FREQ);
    localparam logic [31:0] T_FRAME      = us_to_cycles(FRAME_PERIOD_US, CLK_FREQ);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  bit_q, bit_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        env_q, mark_d;
    logic        restart;
    logic        carrier;
    logic [31:0] dur;
    logic        last;
    logic [31:0] frame_word;

    // Frame word, LSB transmitted first.
    assign frame_word = {~cmd, cmd, (ext_addr ? addr[15:8] : ~addr[7:0]), addr[7:0]};

    // Next-state, segment timing and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = 32'(cnt_q + 32'd1);
        fcnt_d  = 32'(fcnt_q + 32'd1);
        sr_d    = sr_q;
        bit_d   = bit_q;
        dur     = '0;

        case (state_q)
            LEAD_MARK:  dur = T_LEAD_MARK;
            LEAD_SPACE: dur = T_LEAD_SPACE;
            BIT_MARK:   dur = T_BIT_MARK;
            BIT_SPACE:  dur = sr_q[0] ? T_BIT1_SPACE : T_BIT0_SPACE;
            STOP_MARK:  dur = T_STOP_MARK;
            REP_MARK:   dur = T_LEAD_MARK;
            REP_SPACE:  dur = T_REP_SPACE;
            REP_STOP:   dur = T_STOP_MARK;
            default:    dur = '0;
        endcase
        last = (cnt_q == 32'(dur - 32'd1));

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                fcnt_d = '0;
                if (send) begin
                    state_d = LEAD_MARK;
                    sr_d    = frame_word;
                    bit_d   = '0;
                end
            end
            LEAD_MARK:  if (last) state_d = LEAD_SPACE;
            LEAD_SPACE: if (last) state_d = BIT_MARK;
            BIT_MARK:   if (last) state_d = BIT_SPACE;
            BIT_SPACE: begin
                if (last) begin
                    sr_d    = {1'b0, sr_q[31:1]};
                    bit_d   = 5'(bit_q + 5'd1);
                    state_d = (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (last) state_d = GAP;
            GAP: begin
                // Hold is only looked at when the frame period expires.
                if (fcnt_q == 32'(T_FRAME - 32'd1)) state_d = hold ? REP_MARK : IDLE;
            end
            REP_MARK:   if (last) state_d = REP_SPACE;
            REP_SPACE:  if (last) state_d = REP_STOP;
            REP_STOP:   if (last) state_d = GAP;
            default:    state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        // Frame period is measured from the start of each lead or repeat mark.
        if ((state_d != state_q) && ((state_d == LEAD_MARK) || (state_d == REP_MARK))) fcnt_d = '0;

        mark_d  = is_mark(state_d);
        restart = mark_d && (state_d != state_q);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == IDLE) && (state_q != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            env_q   <= mark_d;
        end
    end

    nec_carrier_gen #(
        .HALF (HALF)
    ) u_carrier (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .gate_i    (mark_d),
        .phase_o   (carrier)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign envelope = env_q;
    assign ir_out   = MODULATE ? carrier : env_q;

endmodule

// File: tb/tb_nec_tx_ext.sv
// Scoreboard bench for nec_tx_ext: expected marks and done pulses are queued by
// the stimulus and consumed by an independent monitor watching the outputs.
module tb_nec_tx_ext;

    localparam int unsigned CLK_HZ = 100_000;
    localparam int unsigned CAR_HZ = 10_000;
    localparam int unsigned HALF_C = CLK_HZ / (2 * CAR_HZ);

    function automatic int unsigned us2c(input int unsigned us);
        longint unsigned p;
        p = longint'(us) * longint'(CLK_HZ);
        return 32'(p / 64'd1_000_000);
    endfunction

    localparam int unsigned LM  = us2c(9000);
    localparam int unsigned LS  = us2c(4500);
    localparam int unsigned BM  = us2c(562);
    localparam int unsigned B0S = us2c(562);
    localparam int unsigned B1S = us2c(1687);
    localparam int unsigned RS  = us2c(2250);
    localparam int unsigned SM  = us2c(562);
    localparam int unsigned FP  = us2c(108000);

    typedef struct {
        int unsigned start;
        int unsigned len;
        bit          lead;
    } mark_t;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        ext_addr;
    logic        send;
    logic        hold;
    logic        busy;
    logic        done;
    logic        envelope;
    logic        ir_out;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    mark_t       mq[$];
    int unsigned dq[$];

    nec_tx_ext #(
        .CLK_FREQ     (CLK_HZ),
        .CARRIER_FREQ (CAR_HZ),
        .MODULATE     (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .cmd      (cmd),
        .ext_addr (ext_addr),
        .send     (send),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .envelope (envelope),
        .ir_out   (ir_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Bit i of the on-air sequence: bytes addr_lo, addr_hi/inverse, cmd, ~cmd, each LSB first.
    function automatic bit frame_bit(input logic [15:0] a, input logic [7:0] c, input bit ext, input int i);
        logic [7:0] b [4];
        b[0] = a[7:0];
        b[1] = ext ? a[15:8] : ~a[7:0];
        b[2] = c;
        b[3] = ~c;
        return b[i / 8][i % 8];
    endfunction

    function automatic int unsigned bit_time(input int unsigned s, input logic [15:0] a,
                                             input logic [7:0] c, input bit ext, input int i);
        int unsigned t;
        t = s + LM + LS;
        for (int j = 0; j < i; j++) t += BM + (frame_bit(a, c, ext, j) ? B1S : B0S);
        return t;
    endfunction

    task automatic push_mark(input int unsigned s, input int unsigned l, input bit ld);
        mark_t m;
        m.start = s;
        m.len   = l;
        m.lead  = ld;
        mq.push_back(m);
    endtask

    task automatic push_frame(input int unsigned s, input logic [15:0] a, input logic [7:0] c,
                              input bit ext, input int nbits);
        push_mark(s, LM, 1'b1);
        for (int i = 0; i < nbits; i++) push_mark(bit_time(s, a, c, ext, i), BM, 1'b0);
        if (nbits == 32) push_mark(bit_time(s, a, c, ext, 32), SM, 1'b0);
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // One send pulse; hold_len>0 keeps hold high that many cycles; poke re-asserts send mid-frame.
    task automatic send_frame(input logic [15:0] a, input logic [7:0] c, input bit ext,
                              input int unsigned hold_len, input bit poke);
        int unsigned s, anc, dn;
        @(negedge clk);
        check("busy_before_send", busy, 0);
        addr = a; cmd = c; ext_addr = ext; send = 1'b1; hold = (hold_len != 0);
        s = cyc + 1;
        push_frame(s, a, c, ext, 32);
        anc = s;
        while (hold_len != 0 && anc + FP <= s + hold_len) begin
            anc += FP;
            push_mark(anc, LM, 1'b1);
            push_mark(anc + LM + RS, SM, 1'b0);
        end
        dn = anc + FP;
        dq.push_back(dn);
        @(negedge clk);
        send = 1'b0;
        if (poke) begin
            wait_cyc(bit_time(s, a, c, ext, 10) + 10);
            send = 1'b1; addr = 16'($urandom); cmd = 8'($urandom); ext_addr = ~ext;
            repeat (20) @(negedge clk);
            send = 1'b0;
        end
        if (hold_len != 0) begin
            wait_cyc(s + hold_len);
            hold = 1'b0;
        end
        wait_cyc(dn + 3);
    endtask

    // Monitor: measures each mark and done pulse against the queued expectations.
    initial begin : monitor
        bit          prev_env;
        int unsigned cur_start, ms, car_err, sp_err;
        bit          exp_ir;
        mark_t       m;
        prev_env = 1'b0; cur_start = 0; car_err = 0; sp_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete(); dq.delete();
                prev_env = 1'b0; car_err = 0; sp_err = 0;
            end else begin
                if (envelope && !prev_env) begin
                    cur_start = cyc; car_err = 0;
                    check("space_ir_zero", sp_err, 0);
                    sp_err = 0;
                    check("mark_expected", mq.size() != 0, 1);
                    if (mq.size() != 0) begin
                        check("mark_start", cyc, mq[0].start);
                        if (mq[0].lead) check("busy_at_lead", busy, 1);
                    end
                end
                if (envelope) begin
                    ms = (mq.size() != 0) ? mq[0].start : cur_start;
                    exp_ir = (((cyc - ms) / HALF_C) % 2) == 0;
                    if (ir_out !== exp_ir) car_err++;
                end else if (ir_out !== 1'b0) sp_err++;
                if (!envelope && prev_env && mq.size() != 0) begin
                    m = mq.pop_front();
                    check("mark_len", cyc - cur_start, m.len);
                    check("carrier", car_err, 0);
                end
                if (done) begin
                    check("done_expected", dq.size() != 0, 1);
                    if (dq.size() != 0) begin
                        check("done_time", cyc, dq.pop_front());
                        check("busy_at_done", busy, 0);
                    end
                end
                prev_env = envelope;
            end
        end
    end

    // Stimulus.
    initial begin : stim
        int unsigned s, t;
        logic [15:0] ra;
        logic [7:0]  rc;
        rst = 1'b1; addr = '0; cmd = '0; ext_addr = 1'b0; send = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_env", envelope, 0);
        check("rst_ir", ir_out, 0);

        // Standard frame, word 0xED1210EF.
        send_frame(16'h00EF, 8'h12, 1'b0, 0, 1'b0);
        // Extended address; send re-asserted with new data at bit 10 must be ignored.
        send_frame(16'h1234, 8'($urandom), 1'b1, 0, 1'b1);
        // Hold for 250 ms: frame plus two repeats.
        send_frame(16'($urandom), 8'($urandom), 1'($urandom), us2c(250_000), 1'b0);

        // Reset in the middle of bit 5.
        ra = 16'($urandom); rc = 8'($urandom);
        @(negedge clk);
        addr = ra; cmd = rc; ext_addr = 1'b0; send = 1'b1;
        s = cyc + 1;
        push_frame(s, ra, rc, 1'b0, 6);
        @(negedge clk);
        send = 1'b0;
        t = bit_time(s, ra, rc, 1'b0, 5) + 20;
        wait_cyc(t);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_env", envelope, 0);
        check("midrst_ir", ir_out, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_env", envelope, 0);
        send_frame(16'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);

        check("marks_consumed", mq.size(), 0);
        check("dones_consumed", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
